cache_control: RTL and testbench

Sequencing FSM for the 2-way, 8-set cache built from the per-way tag, valid, dirty and data arrays plus a shared LRU array. It arbitrates each CPU request into a hit response, a dirty-victim writeback or a line fill, and drives every array's load strobe and the physical-memory handshake. It also keeps saturating hit and miss counters for performance readout. Sits between the CPU memory port and the arbiter in front of physical memory; the cache datapath (arrays, tag compare, muxes) is a separate block.

---
 rtl/cache_control.sv | 152 +++++++++++++++
 tb/tb_cache_control.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_control.sv
// Control FSM for the 2-way, 8-set cache: hit response, victim writeback,
// line fill, array strobes, pmem handshake and saturating hit/miss counters.
module cache_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [1:0]       hit,
  input  logic             lru,
  input  logic             victim_dirty,
  input  logic             pmem_resp,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic             pmem_addr_sel,
  output logic             way_sel,
  output logic             data_src,
  output logic [1:0]       load_data,
  output logic [1:0]       load_tag,
  output logic [1:0]       load_valid,
  output logic [1:0]       load_dirty,
  output logic             dirty_in,
  output logic             load_lru,
  output logic             lru_in,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } state_e;

  state_e           state_q, state_d;
  logic             refilled_q, refilled_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] miss_q, miss_d;

  logic       req;
  logic       hit_way;
  logic [1:0] hit_oh;
  logic [1:0] vic_oh;

  assign req     = mem_read | mem_write;
  // way 0 wins when both tags match
  assign hit_way = ~hit[0];
  assign hit_oh  = hit_way ? 2'b10 : 2'b01;
  assign vic_oh  = lru ? 2'b10 : 2'b01;

  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      refilled_q <= 1'b0;
      hit_q      <= '0;
      miss_q     <= '0;
    end else begin
      state_q    <= state_d;
      refilled_q <= refilled_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    refilled_d    = refilled_q;
    hit_d         = hit_q;
    miss_d        = miss_q;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    way_sel       = 1'b0;
    data_src      = 1'b0;
    load_data     = 2'b00;
    load_tag      = 2'b00;
    load_valid    = 2'b00;
    load_dirty    = 2'b00;
    dirty_in      = 1'b0;
    load_lru      = 1'b0;
    lru_in        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req && (|hit)) begin
          mem_resp   = 1'b1;
          way_sel    = hit_way;
          load_lru   = 1'b1;
          lru_in     = ~hit_way;
          refilled_d = 1'b0;
          if (mem_write) begin
            load_data  = hit_oh;
            load_dirty = hit_oh;
            dirty_in   = 1'b1;
          end
          // the retry after a fill is not a real hit
          if (!refilled_q && !(&hit_q))
            hit_d = hit_q + CNT_W'(1);
        end else if (req) begin
          if (!(&miss_q))
            miss_d = miss_q + CNT_W'(1);
          state_d = victim_dirty ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        way_sel       = lru;
        if (pmem_resp)
          state_d = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        way_sel   = lru;
        if (pmem_resp) begin
          load_data  = vic_oh;
          load_tag   = vic_oh;
          load_valid = vic_oh;
          load_dirty = vic_oh;
          data_src   = 1'b1;
          refilled_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // keep every output quiet while reset is held
    if (rst) begin
      mem_resp      = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      pmem_addr_sel = 1'b0;
      way_sel       = 1'b0;
      data_src      = 1'b0;
      load_data     = 2'b00;
      load_tag      = 2'b00;
      load_valid    = 2'b00;
      load_dirty    = 2'b00;
      dirty_in      = 1'b0;
      load_lru      = 1'b0;
      lru_in        = 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: hit vector table plus miss,
// writeback, reset and counter-saturation sequences.
module tb_cache_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [1:0]  hit;
  logic        lru, victim_dirty, pmem_resp;
  logic        mem_resp, pmem_read, pmem_write, pmem_addr_sel;
  logic        way_sel, data_src;
  logic [1:0]  load_data, load_tag, load_valid, load_dirty;
  logic        dirty_in, load_lru, lru_in;
  logic [15:0] hit_count, miss_count;

  logic        s_rd;
  logic [1:0]  s_hit;
  logic        s_mem_resp, s_pmem_read, s_pmem_write, s_pmem_addr_sel;
  logic        s_way_sel, s_data_src;
  logic [1:0]  s_load_data, s_load_tag, s_load_valid, s_load_dirty;
  logic        s_dirty_in, s_load_lru, s_lru_in;
  logic [1:0]  s_hit_count, s_miss_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cache_control dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .hit(hit), .lru(lru), .victim_dirty(victim_dirty),
    .pmem_resp(pmem_resp), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_addr_sel(pmem_addr_sel), .way_sel(way_sel),
    .data_src(data_src), .load_data(load_data),
    .load_tag(load_tag), .load_valid(load_valid),
    .load_dirty(load_dirty), .dirty_in(dirty_in),
    .load_lru(load_lru), .lru_in(lru_in),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  cache_control #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .mem_read(s_rd), .mem_write(1'b0),
    .hit(s_hit), .lru(1'b0), .victim_dirty(1'b0),
    .pmem_resp(1'b0), .mem_resp(s_mem_resp),
    .pmem_read(s_pmem_read), .pmem_write(s_pmem_write),
    .pmem_addr_sel(s_pmem_addr_sel), .way_sel(s_way_sel),
    .data_src(s_data_src), .load_data(s_load_data),
    .load_tag(s_load_tag), .load_valid(s_load_valid),
    .load_dirty(s_load_dirty), .dirty_in(s_dirty_in),
    .load_lru(s_load_lru), .lru_in(s_lru_in),
    .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  // {mem_resp,pmem_read,pmem_write,addr_sel,way_sel,data_src,
  //  load_data,load_tag,load_valid,load_dirty,dirty_in,load_lru,lru_in}
  logic [16:0] outs;
  assign outs = {mem_resp, pmem_read, pmem_write, pmem_addr_sel,
                 way_sel, data_src, load_data, load_tag, load_valid,
                 load_dirty, dirty_in, load_lru, lru_in};

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [1:0]  h;
    logic        pr;
    logic [16:0] exp_o;
    logic [15:0] exp_hc;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    mem_read = 0; mem_write = 0; hit = 2'b00;
    lru = 0; victim_dirty = 0; pmem_resp = 0;
  endtask

  initial begin
    vecs[0] = '{"idle",        0, 0, 2'b00, 0, 17'b0_000_00_00_00_00_00_0_0_0, 16'd0};
    vecs[1] = '{"rd_hit_w1",   1, 0, 2'b10, 0, 17'b1_000_10_00_00_00_00_0_1_0, 16'd1};
    vecs[2] = '{"wr_hit_w0",   0, 1, 2'b01, 0, 17'b1_000_00_01_00_00_01_1_1_1, 16'd2};
    vecs[3] = '{"rd_hit_both", 1, 0, 2'b11, 0, 17'b1_000_00_00_00_00_00_0_1_1, 16'd3};
    vecs[4] = '{"rdwr_hit_w1", 1, 1, 2'b10, 0, 17'b1_000_10_10_00_00_10_1_1_0, 16'd4};
    vecs[5] = '{"idle_presp",  0, 0, 2'b11, 1, 17'b0_000_00_00_00_00_00_0_0_0, 16'd4};
    vecs[6] = '{"wr_hit_w1",   0, 1, 2'b10, 0, 17'b1_000_10_10_00_00_10_1_1_0, 16'd5};

    rst = 1; s_rd = 0; s_hit = 2'b00;
    idle_in();
    mem_read = 1; hit = 2'b01;
    @(negedge clk);
    chk("rst_outs", 32'(outs), 32'd0);
    tick();
    idle_in();
    rst = 0;
    @(negedge clk);
    chk("reset_outs", 32'(outs), 32'd0);
    chk("reset_hc", 32'(hit_count), 32'd0);
    chk("reset_mc", 32'(miss_count), 32'd0);
    tick();

    foreach (vecs[i]) begin
      mem_read = vecs[i].rd; mem_write = vecs[i].wr;
      hit = vecs[i].h; pmem_resp = vecs[i].pr;
      @(negedge clk);
      chk({vecs[i].name, "_o"}, 32'(outs), 32'(vecs[i].exp_o));
      tick();
      chk({vecs[i].name, "_hc"}, 32'(hit_count), 32'(vecs[i].exp_hc));
    end
    idle_in();

    // clean read miss, victim way 1, fill after 4 cycles
    mem_read = 1; hit = 2'b00; lru = 1; victim_dirty = 0;
    @(negedge clk);
    chk("cm_idle_resp", 32'(mem_resp), 32'd0);
    chk("cm_idle_pr", 32'(pmem_read), 32'd0);
    tick();
    chk("cm_mc", 32'(miss_count), 32'd1);
    for (int c = 0; c < 4; c++) begin
      pmem_resp = (c == 3);
      @(negedge clk);
      chk("cm_alloc_pr", 32'({pmem_read, pmem_write, pmem_addr_sel}), 32'b100);
      if (c == 3)
        chk("cm_fill", 32'({load_data, load_tag, load_valid, load_dirty,
                            dirty_in, data_src, way_sel}), 32'b10_10_10_10_0_1_1);
      else
        chk("cm_wait", 32'({load_data, load_tag, load_valid, mem_resp}), 32'd0);
      tick();
    end
    pmem_resp = 0; hit = 2'b10;
    @(negedge clk);
    chk("cm_retry", 32'({mem_resp, pmem_read, lru_in, load_lru}), 32'b1001);
    tick();
    chk("cm_hc", 32'(hit_count), 32'd5);
    chk("cm_mc2", 32'(miss_count), 32'd1);
    @(negedge clk);
    tick();
    chk("cm_next_hit", 32'(hit_count), 32'd6);
    idle_in();

    // dirty write miss, victim way 0
    mem_write = 1; hit = 2'b00; lru = 0; victim_dirty = 1;
    @(negedge clk);
    chk("dm_idle_resp", 32'(mem_resp), 32'd0);
    tick();
    victim_dirty = 0;
    chk("dm_mc", 32'(miss_count), 32'd2);
    for (int c = 0; c < 3; c++) begin
      pmem_resp = (c == 2);
      @(negedge clk);
      chk("dm_wb", 32'({pmem_write, pmem_read, pmem_addr_sel, way_sel}),
          32'b1010);
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      pmem_resp = (c == 1);
      @(negedge clk);
      chk("dm_alloc", 32'({pmem_read, pmem_write, pmem_addr_sel}), 32'b100);
      if (c == 1)
        chk("dm_fill", 32'({load_data, load_dirty, dirty_in, data_src}),
            32'b01_01_0_1);
      tick();
    end
    pmem_resp = 0; hit = 2'b01;
    @(negedge clk);
    chk("dm_retry", 32'({mem_resp, load_data, load_dirty, dirty_in,
                         data_src, lru_in, pmem_read, pmem_write}),
        32'b1_01_01_1_0_1_0_0);
    tick();
    chk("dm_hc", 32'(hit_count), 32'd6);
    idle_in();

    // reset in the middle of a fill
    mem_read = 1; lru = 1;
    tick();
    mem_read = 0;
    @(negedge clk);
    chk("rs_alloc", 32'(pmem_read), 32'd1);
    rst = 1;
    #1;
    chk("rs_drop", 32'({pmem_read, pmem_write, mem_resp}), 32'd0);
    chk("rs_cnt", 32'({hit_count, miss_count}), 32'd0);
    tick();
    @(negedge clk);
    rst = 0;
    pmem_resp = 1;
    #1;
    chk("rs_late", 32'(outs), 32'd0);
    tick();
    pmem_resp = 0;
    @(negedge clk);
    chk("rs_idle", 32'(outs), 32'd0);
    chk("rs_cnt2", 32'({hit_count, miss_count}), 32'd0);

    // saturation on the narrow instance
    tick();
    s_rd = 1; s_hit = 2'b01;
    repeat (2) tick();
    chk("sat_two", 32'(s_hit_count), 32'd2);
    repeat (3) tick();
    s_rd = 0;
    chk("sat_five", 32'(s_hit_count), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
